// File: rtl/overture_sequencer_pkg.sv
// Shared decode constants, FSM states and condition evaluation for the OVERTURE sequencer.
package overture_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_IMM  = 2'b00,
    MODE_CALC = 2'b01,
    MODE_COPY = 2'b10,
    MODE_COND = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ALU_OR   = 3'd0,
    ALU_NAND = 3'd1,
    ALU_NOR  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_ADD  = 3'd4,
    ALU_SUB  = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    CC_NEVER  = 3'd0,
    CC_EQ     = 3'd1,
    CC_LT     = 3'd2,
    CC_LE     = 3'd3,
    CC_ALWAYS = 3'd4,
    CC_NE     = 3'd5,
    CC_GE     = 3'd6,
    CC_GT     = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_INWAIT = 2'd2
  } state_e;

  localparam logic [2:0] IDX_IN  = 3'd6;
  localparam logic [2:0] IDX_OUT = 3'd7;

  // R3 is tested as a signed byte.
  function automatic logic cond_true(input cond_e cc, input logic [7:0] v);
    logic zero;
    logic neg;
    logic res;
    zero = (v == 8'd0);
    neg  = v[7];
    case (cc)
      CC_NEVER:  res = 1'b0;
      CC_EQ:     res = zero;
      CC_LT:     res = neg;
      CC_LE:     res = neg | zero;
      CC_ALWAYS: res = 1'b1;
      CC_NE:     res = ~zero;
      CC_GE:     res = ~neg;
      CC_GT:     res = ~neg & ~zero;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/overture_sequencer_regfile.sv
// R0-R5 storage: one write port, one combinational read port, fixed R0..R3 taps.
module overture_regfile
  import overture_sequencer_pkg::*;
#(
  parameter int UUID = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] widx,
  input  logic [7:0] wdata,
  input  logic [2:0] ridx,
  output logic [7:0] rdata,
  output logic [7:0] r0,
  output logic [7:0] r1,
  output logic [7:0] r2,
  output logic [7:0] r3
);

  logic [5:0][7:0] regs;
  logic            unused_uuid;

  assign unused_uuid = ^UUID;

  // Indexes 6 (input) and 7 (output/zero) have no storage behind them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      regs <= '0;
    else if (we && widx < IDX_IN) regs[widx] <= wdata;
  end

  assign rdata = (ridx < IDX_IN) ? regs[ridx] : 8'd0;
  assign r0    = regs[0];
  assign r1    = regs[1];
  assign r2    = regs[2];
  assign r3    = regs[3];

endmodule

// File: rtl/overture_sequencer.sv
// OVERTURE instruction sequencer: fetch/exec/inwait FSM, register file, ALU drive and byte I/O.
module overture_sequencer
  import overture_sequencer_pkg::*;
#(
  parameter int    UUID = 0,
  parameter string NAME = ""
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] prog_addr,
  output logic       prog_req,
  input  logic       prog_valid,
  input  logic [7:0] prog_data,
  output logic [7:0] alu_code,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_result,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid
);

  state_e     state, state_nxt;
  logic [7:0] pc, pc_nxt, ir;
  logic       we, out_load;
  logic [2:0] widx, src, dst;
  logic [7:0] wdata, rdata, r0, r3;
  mode_e      mode;
  logic       unused_params;

  assign unused_params = (NAME == "") ^ UUID[0];

  assign mode = mode_e'(ir[7:6]);
  assign src  = ir[5:3];
  assign dst  = ir[2:0];

  overture_regfile #(.UUID(UUID ^ 32'h1)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .widx  (widx),
    .wdata (wdata),
    .ridx  (src),
    .rdata (rdata),
    .r0    (r0),
    .r1    (alu_a),
    .r2    (alu_b),
    .r3    (r3)
  );

  assign prog_addr = pc;
  assign prog_req  = (state == ST_FETCH) && !rst;
  assign alu_code  = {5'b0, ir[2:0]};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    we        = 1'b0;
    widx      = dst;
    wdata     = rdata;
    out_load  = 1'b0;
    in_ready  = 1'b0;
    case (state)
      ST_FETCH: if (prog_valid) state_nxt = ST_EXEC;
      ST_EXEC: begin
        state_nxt = ST_FETCH;
        pc_nxt    = pc + 8'd1;
        case (mode)
          MODE_IMM: begin
            we    = 1'b1;
            widx  = 3'd0;
            wdata = {2'b00, ir[5:0]};
          end
          MODE_CALC: begin
            we    = 1'b1;
            widx  = 3'd3;
            wdata = alu_result;
          end
          MODE_COPY: begin
            if (src == IDX_IN) begin
              // Input copies retire from INWAIT, so the PC holds here.
              state_nxt = ST_INWAIT;
              pc_nxt    = pc;
            end else begin
              we       = 1'b1;
              out_load = (dst == IDX_OUT);
            end
          end
          MODE_COND: if (cond_true(cond_e'(ir[2:0]), r3)) pc_nxt = r0;
        endcase
      end
      ST_INWAIT: begin
        in_ready = in_valid;
        wdata    = in_data;
        if (in_valid) begin
          we        = 1'b1;
          out_load  = (dst == IDX_OUT);
          pc_nxt    = pc + 8'd1;
          state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FETCH;
      pc        <= 8'd0;
      ir        <= 8'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      out_valid <= out_load;
      if (state == ST_FETCH && prog_valid) ir <= prog_data;
      if (out_load) out_data <= wdata;
    end
  end

endmodule

// File: tb/tb_overture_sequencer.sv
// Scoreboard bench: an instruction-level model predicts fetch addresses, output bytes and final registers.
module tb_overture_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] prog_addr;
  logic       prog_req;
  logic       prog_valid = 1'b0;
  logic [7:0] prog_data = 8'd0;
  logic [7:0] alu_code, alu_a, alu_b, alu_result;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  overture_sequencer #(.UUID(0), .NAME("dut")) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_addr  (prog_addr),
    .prog_req   (prog_req),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .alu_code   (alu_code),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid)
  );

  // External compact ALU.
  function automatic logic [7:0] alu_model(input logic [7:0] code, input logic [7:0] a, input logic [7:0] b);
    case (code)
      8'd0:    return a | b;
      8'd1:    return ~(a & b);
      8'd2:    return ~(a | b);
      8'd3:    return a & b;
      8'd4:    return a + b;
      8'd5:    return a - b;
      default: return 8'd0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_code, alu_a, alu_b);

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] mem [256];
  logic [7:0] m_pc;
  logic [7:0] m_r [6];
  logic [7:0] exp_addr[$];
  logic [7:0] exp_out[$];
  logic [7:0] in_q[$];
  logic [7:0] dir_in[$];

  // Stimulus controls shared with driver/monitor
  bit mon_en = 1'b0;
  bit rand_mode = 1'b0;
  bit waiting = 1'b0;
  int fetches_left = 0;
  int pstall_fixed = 0, istall_fixed = 0;
  int pstall_tgt = 0, pstall_cnt = 0, istall_tgt = 0, istall_cnt = 0;

  task automatic iss_run(input int n);
    logic [7:0]        ins, v;
    logic signed [7:0] s;
    bit                take;
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back(m_pc);
      ins = mem[m_pc];
      case (ins[7:6])
        2'b00: begin
          m_r[0] = {2'b00, ins[5:0]};
          m_pc   = m_pc + 8'd1;
        end
        2'b01: begin
          m_r[3] = alu_model({5'b0, ins[2:0]}, m_r[1], m_r[2]);
          m_pc   = m_pc + 8'd1;
        end
        2'b10: begin
          if (ins[5:3] == 3'd6) begin
            if (dir_in.size() > 0) v = dir_in.pop_front();
            else v = 8'($urandom);
            in_q.push_back(v);
          end else if (ins[5:3] == 3'd7) v = 8'd0;
          else v = m_r[ins[5:3]];
          if (ins[2:0] < 3'd6) m_r[ins[2:0]] = v;
          else if (ins[2:0] == 3'd7) exp_out.push_back(v);
          m_pc = m_pc + 8'd1;
        end
        default: begin
          s = m_r[3];
          case (ins[2:0])
            3'd0:    take = 1'b0;
            3'd1:    take = (s == 0);
            3'd2:    take = (s < 0);
            3'd3:    take = (s <= 0);
            3'd4:    take = 1'b1;
            3'd5:    take = (s != 0);
            3'd6:    take = (s >= 0);
            default: take = (s > 0);
          endcase
          if (take) m_pc = m_r[0];
          else m_pc = m_pc + 8'd1;
        end
      endcase
    end
  endtask

  // Program memory and input byte driver
  initial begin : drv
    bit p_acc, i_acc;
    p_acc = 1'b0;
    i_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (p_acc) begin
          fetches_left--;
          pstall_cnt = 0;
          pstall_tgt = rand_mode ? int'($urandom_range(0, 3)) : pstall_fixed;
        end
        if (i_acc) begin
          in_q.delete(0);
          istall_cnt = 0;
          istall_tgt = rand_mode ? int'($urandom_range(0, 3)) : istall_fixed;
        end
        prog_valid = 1'b0;
        in_valid   = 1'b0;
        if (!rst) begin
          if (prog_req && fetches_left > 0) begin
            if (pstall_cnt < pstall_tgt) pstall_cnt++;
            else begin
              prog_valid = 1'b1;
              prog_data  = mem[prog_addr];
            end
          end
          if (in_q.size() > 0) begin
            in_data = in_q[0];
            if (waiting) begin
              if (istall_cnt < istall_tgt) istall_cnt++;
              else in_valid = 1'b1;
            end else if (rand_mode && $urandom_range(0, 3) == 0) in_valid = 1'b1;
          end
        end
        #1;
        p_acc = prog_valid && prog_req;
        i_acc = in_valid && in_ready;
      end else begin
        p_acc = 1'b0;
        i_acc = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT fetches or emits a byte
  initial begin : mon
    bit         exec_pend, ov_exp, prev_stall, ov_nxt;
    logic [7:0] ex_ir, prev_addr;
    exec_pend = 0; ov_exp = 0; prev_stall = 0; ex_ir = 0; prev_addr = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst || !mon_en) begin
        exec_pend = 0; ov_exp = 0; prev_stall = 0; waiting = 0;
      end else begin
        ov_nxt = 1'b0;
        check("out_valid", {7'd0, out_valid}, {7'd0, ov_exp});
        if (out_valid && exp_out.size() > 0) check("out_data", out_data, exp_out.pop_front());
        check("in_ready", {7'd0, in_ready}, {7'd0, waiting & in_valid});
        if (waiting && in_valid) begin
          waiting = 1'b0;
          if (ex_ir[2:0] == 3'd7) ov_nxt = 1'b1;
        end
        if (exec_pend) begin
          check("alu_code", alu_code, {5'b0, ex_ir[2:0]});
          if (ex_ir[7:6] == 2'b10 && ex_ir[5:3] == 3'd6) waiting = 1'b1;
          else if (ex_ir[7:6] == 2'b10 && ex_ir[2:0] == 3'd7) ov_nxt = 1'b1;
          exec_pend = 1'b0;
        end
        if (prev_stall && prog_req) check("prog_addr_hold", prog_addr, prev_addr);
        if (prog_req && prog_valid) begin
          if (exp_addr.size() > 0) check("fetch_addr", prog_addr, exp_addr.pop_front());
          exec_pend = 1'b1;
          ex_ir     = prog_data;
        end
        prev_stall = prog_req && !prog_valid;
        prev_addr  = prog_addr;
        ov_exp     = ov_nxt;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    mon_en     = 1'b0;
    prog_valid = 1'b0;
    in_valid   = 1'b0;
    exp_addr.delete();
    exp_out.delete();
    in_q.delete();
    fetches_left = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input int n, input string tag);
    int cyc;
    m_pc = 8'd0;
    for (int i = 0; i < 6; i++) m_r[i] = 8'd0;
    iss_run(n);
    fetches_left = n;
    pstall_cnt = 0;
    istall_cnt = 0;
    pstall_tgt = rand_mode ? int'($urandom_range(0, 3)) : pstall_fixed;
    istall_tgt = rand_mode ? int'($urandom_range(0, 3)) : istall_fixed;
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while ((fetches_left > 0 || in_q.size() > 0 || exp_out.size() > 0 || waiting) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d fetches and %0d outputs outstanding", tag, fetches_left, exp_out.size());
    end
    repeat (3) @(negedge clk);
    #3;
    check({tag, "_final_pc"}, prog_addr, m_pc);
    check({tag, "_final_r1"}, alu_a, m_r[1]);
    check({tag, "_final_r2"}, alu_b, m_r[2]);
    check({tag, "_missing_out"}, 8'(exp_out.size()), 8'd0);
  endtask

  initial begin : main
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    #2;
    check("rst_prog_req", {7'd0, prog_req}, 8'd0);
    check("rst_prog_addr", prog_addr, 8'd0);
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_out_data", out_data, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("post_rst_req", {7'd0, prog_req}, 8'd1);
    check("post_rst_addr", prog_addr, 8'd0);

    // Abort an input wait with reset
    @(negedge clk);
    prog_valid = 1'b1;
    prog_data  = 8'hB1;
    @(negedge clk);
    prog_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("inwait_req", {7'd0, prog_req}, 8'd0);
    check("inwait_ready", {7'd0, in_ready}, 8'd0);
    check("inwait_alu_code", alu_code, 8'd1);
    rst = 1'b1;
    #2;
    check("abort_prog_req", {7'd0, prog_req}, 8'd0);
    check("abort_prog_addr", prog_addr, 8'd0);
    check("abort_in_ready", {7'd0, in_ready}, 8'd0);
    check("abort_out_valid", {7'd0, out_valid}, 8'd0);
    check("abort_out_data", out_data, 8'd0);
    check("abort_alu_code", alu_code, 8'd0);
    check("abort_alu_a", alu_a, 8'd0);
    check("abort_alu_b", alu_b, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("abort_release_req", {7'd0, prog_req}, 8'd1);
    check("abort_release_addr", prog_addr, 8'd0);

    // Directed program: arithmetic, output, input stall, jumps, PC wrap, fetch stall
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h05; mem[8'h01] = 8'h81; mem[8'h02] = 8'h03; mem[8'h03] = 8'h82;
    mem[8'h04] = 8'h44; mem[8'h05] = 8'h9F; mem[8'h06] = 8'h45; mem[8'h07] = 8'h9F;
    mem[8'h08] = 8'hB1; mem[8'h09] = 8'hB3; mem[8'h0A] = 8'h10; mem[8'h0B] = 8'hC2;
    mem[8'h10] = 8'hC7; mem[8'h11] = 8'hB0; mem[8'h12] = 8'hC4; mem[8'hFF] = 8'h00;
    dir_in.delete();
    dir_in.push_back(8'h7F);
    dir_in.push_back(8'h80);
    dir_in.push_back(8'hFF);
    rand_mode    = 1'b0;
    pstall_fixed = 3;
    istall_fixed = 4;
    run(16, "directed");

    // Same program without stalls
    do_reset();
    dir_in.push_back(8'h7F);
    dir_in.push_back(8'h80);
    dir_in.push_back(8'hFF);
    pstall_fixed = 0;
    istall_fixed = 0;
    run(16, "directed_fast");

    // Random programs with random stalls
    rand_mode = 1'b1;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      dir_in.delete();
      run(80, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
